// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU: M-extension decode constants and
// the multiply/divide unit state type.
package mini_cpu_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int MULDIV_ITER = 32;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX,
    MD_DONE
  } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide share one 64-bit work register, with sign fix-up after the loop.
module ex_muldiv
  import mini_cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [4:0]      in_rd_addr,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd_addr
);

  muldiv_state_t       state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [4:0]          rd_q, rd_d;
  logic [XLEN-1:0]     divisor_q, divisor_d;
  logic [2*XLEN-1:0]   work_q, work_d;
  logic                negQuo_q, negQuo_d;
  logic                negRem_q, negRem_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          rdOut_q, rdOut_d;

  logic                accept;
  logic                isDiv;
  logic                rs1Signed, rs2Signed;
  logic                sign1, sign2;
  logic [XLEN-1:0]     mag1, mag2;
  logic                divZero, divOvf, fastPath;
  logic [XLEN-1:0]     fastResult;
  logic [XLEN:0]       mulSum;
  logic [2*XLEN-1:0]   mulNext;
  logic [XLEN:0]       trial;
  logic                divOk;
  logic [2*XLEN-1:0]   divNext;
  logic [2*XLEN-1:0]   prodFixed;
  logic [XLEN-1:0]     quoFixed, remFixed;
  logic [XLEN-1:0]     fixResult;

  // Operand decode for the op currently presented by ID/EX.
  always_comb begin
    isDiv     = in_funct3[2];
    rs1Signed = (in_funct3 == F3_MULH) || (in_funct3 == F3_MULHSU) ||
                (in_funct3 == F3_DIV)  || (in_funct3 == F3_REM);
    rs2Signed = (in_funct3 == F3_MULH) || (in_funct3 == F3_DIV) ||
                (in_funct3 == F3_REM);
    sign1     = rs1Signed & in_rs1_data[XLEN-1];
    sign2     = rs2Signed & in_rs2_data[XLEN-1];
    mag1      = sign1 ? -in_rs1_data : in_rs1_data;
    mag2      = sign2 ? -in_rs2_data : in_rs2_data;
    divZero   = isDiv && (in_rs2_data == '0);
    divOvf    = ((in_funct3 == F3_DIV) || (in_funct3 == F3_REM)) &&
                (in_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                (in_rs2_data == '1);
    fastPath  = divZero || divOvf;
    // Overflow DIV returns the dividend itself (most negative value).
    if (divZero) fastResult = in_funct3[1] ? in_rs1_data : '1;
    else         fastResult = in_funct3[1] ? '0 : in_rs1_data;
  end

  // One iteration of each algorithm; the upper half holds the running
  // partial product or the remainder, the lower half the multiplier or quotient.
  always_comb begin
    mulSum  = {1'b0, work_q[2*XLEN-1:XLEN]} + {1'b0, divisor_q};
    mulNext = work_q[0] ? {mulSum, work_q[XLEN-1:1]}
                        : {1'b0, work_q[2*XLEN-1:1]};
    trial   = {1'b0, work_q[2*XLEN-2:XLEN-1]} - {1'b0, divisor_q};
    divOk   = work_q[2*XLEN-1] | ~trial[XLEN];
    divNext = divOk ? {trial[XLEN-1:0], work_q[XLEN-2:0], 1'b1}
                    : {work_q[2*XLEN-2:0], 1'b0};
  end

  always_comb begin
    prodFixed = negQuo_q ? -work_q : work_q;
    quoFixed  = negQuo_q ? -work_q[XLEN-1:0] : work_q[XLEN-1:0];
    remFixed  = negRem_q ? -work_q[2*XLEN-1:XLEN] : work_q[2*XLEN-1:XLEN];
    case (funct3_q)
      F3_MUL:                      fixResult = prodFixed[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fixResult = prodFixed[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             fixResult = quoFixed;
      default:                     fixResult = remFixed;
    endcase
  end

  assign accept = start && !flush && ((state_q == MD_IDLE) || (state_q == MD_DONE));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    divisor_d = divisor_q;
    work_d    = work_q;
    negQuo_d  = negQuo_q;
    negRem_d  = negRem_q;
    result_d  = result_q;
    rdOut_d   = rdOut_q;

    case (state_q)
      MD_IDLE, MD_DONE: begin
        state_d = MD_IDLE;
        if (accept) begin
          funct3_d  = in_funct3;
          rd_d      = in_rd_addr;
          negQuo_d  = sign1 ^ sign2;
          negRem_d  = sign1;
          cnt_d     = '0;
          divisor_d = isDiv ? mag2 : mag1;
          work_d    = {{XLEN{1'b0}}, isDiv ? mag1 : mag2};
          if (fastPath) begin
            state_d  = MD_DONE;
            result_d = fastResult;
            rdOut_d  = in_rd_addr;
          end else begin
            state_d  = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        work_d = funct3_q[2] ? divNext : mulNext;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'(MULDIV_ITER - 1)) state_d = MD_FIX;
      end
      MD_FIX: begin
        result_d = fixResult;
        rdOut_d  = rd_q;
        state_d  = MD_DONE;
      end
      default: state_d = MD_IDLE;
    endcase

    // An aborted op leaves the previously returned result visible.
    if (flush) begin
      state_d  = MD_IDLE;
      cnt_d    = '0;
      result_d = result_q;
      rdOut_d  = rdOut_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      divisor_q <= '0;
      work_q    <= '0;
      negQuo_q  <= 1'b0;
      negRem_q  <= 1'b0;
      result_q  <= '0;
      rdOut_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      divisor_q <= divisor_d;
      work_q    <= work_d;
      negQuo_q  <= negQuo_d;
      negRem_q  <= negRem_d;
      result_q  <= result_d;
      rdOut_q   <= rdOut_d;
    end
  end

  assign stall_req   = accept || (state_q == MD_CALC) || (state_q == MD_FIX);
  assign done        = (state_q == MD_DONE);
  assign out_result  = result_q;
  assign out_rd_addr = rdOut_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed M-extension cases with literal
// results plus a randomized phase checked every cycle against a reference model.
module tb_ex_muldiv;
  import mini_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic [4:0]  in_rd_addr = '0;
  logic        stall_req;
  logic        done;
  logic [31:0] out_result;
  logic [4:0]  out_rd_addr;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .flush       (flush),
    .in_funct3   (in_funct3),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .in_rd_addr  (in_rd_addr),
    .stall_req   (stall_req),
    .done        (done),
    .out_result  (out_result),
    .out_rd_addr (out_rd_addr)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an M-extension op, straight from 64-bit arithmetic.
  function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (f3)
      F3_MUL:    begin p = ua * ub; return p[31:0];  end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      F3_DIVU: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit isFast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (f3[2] && b == 0) ||
           ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF);
  endfunction

  // Reference timeline: an accepted op owns the unit until its done cycle.
  bit          mPending = 1'b0;
  longint      mEc = 0;
  longint      mDoneAt = 0;
  logic [31:0] mPendRes = '0, mHeldRes = '0;
  logic [4:0]  mPendRd = '0, mHeldRd = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mPending = 1'b0;
      mHeldRes = '0;
      mHeldRd  = '0;
    end else begin
      bit busy;
      busy = mPending && (mEc < mDoneAt);
      if (flush) begin
        mPending = 1'b0;
      end else if (start && !busy) begin
        mPending = 1'b1;
        mDoneAt  = mEc + (isFast(in_funct3, in_rs1_data, in_rs2_data) ? 1 : 34);
        mPendRes = refResult(in_funct3, in_rs1_data, in_rs2_data);
        mPendRd  = in_rd_addr;
      end else if (mPending && mEc >= mDoneAt) begin
        mPending = 1'b0;
      end
      mEc++;
      if (mPending && mEc == mDoneAt) begin
        mHeldRes = mPendRes;
        mHeldRd  = mPendRd;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      bit eBusy, eDone, eStall;
      eBusy  = mPending && (mEc < mDoneAt);
      eDone  = mPending && (mEc == mDoneAt);
      eStall = eBusy || (start && !flush && !eBusy);
      checkOutput("done", {31'b0, done}, {31'b0, eDone});
      checkOutput("stall_req", {31'b0, stall_req}, {31'b0, eStall});
      checkOutput("out_result", out_result, mHeldRes);
      checkOutput("out_rd_addr", {27'b0, out_rd_addr}, {27'b0, mHeldRd});
    end
  end

  // Presents one op for a single cycle (called just after a clock edge with
  // the unit able to accept) and waits a bounded time for its done strobe.
  task automatic applyStimulus(input string name, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic [31:0] expRes, input int expLat);
    int lat;
    start       = 1'b1;
    in_funct3   = f3;
    in_rs1_data = a;
    in_rs2_data = b;
    in_rd_addr  = rd;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, " result"}, out_result, expRes);
    checkOutput({name, " rd"}, {27'b0, out_rd_addr}, {27'b0, rd});
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2 reset = 1'b0;
    #10;
    checkOutput("reset done", {31'b0, done}, 32'h0);
    checkOutput("reset stall_req", {31'b0, stall_req}, 32'h0);
    checkOutput("reset out_result", out_result, 32'h0);
    checkOutput("reset out_rd_addr", {27'b0, out_rd_addr}, 32'h0);
    #5 reset = 1'b1;
    @(posedge clk); #1;

    applyStimulus("MUL 7*-3",      F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34);
    applyStimulus("MUL b2b",       F3_MUL,    32'd123,      32'd1000,     5'd9,  32'd123000,   34);
    applyStimulus("MULH min*min",  F3_MULH,   32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 34);
    applyStimulus("MULHU max*max", F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 34);
    applyStimulus("MULHSU -1*max", F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 34);
    applyStimulus("DIV -7/2",      F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 34);
    applyStimulus("REM -7/2",      F3_REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 34);
    applyStimulus("DIVU big/2",    F3_DIVU,   32'hFFFFFFF9, 32'd2,        5'd7,  32'h7FFFFFFC, 34);
    applyStimulus("DIVU 5/0",      F3_DIVU,   32'd5,        32'd0,        5'd8,  32'hFFFFFFFF, 1);
    applyStimulus("REMU 5/0",      F3_REMU,   32'd5,        32'd0,        5'd10, 32'd5,        1);
    applyStimulus("DIV ovf",       F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1);
    applyStimulus("REM ovf",       F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h0,        1);
    applyStimulus("DIVU prev",     F3_DIVU,   32'hFFFFFFF9, 32'd2,        5'd12, 32'h7FFFFFFC, 34);

    // Abort a divide partway through; the last result must stay visible.
    start = 1'b1; in_funct3 = F3_DIV; in_rs1_data = 32'd100; in_rs2_data = 32'd7; in_rd_addr = 5'd13;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush done", {31'b0, done}, 32'h0);
    checkOutput("flush stall_req", {31'b0, stall_req}, 32'h0);
    checkOutput("flush kept result", out_result, 32'h7FFFFFFC);
    checkOutput("flush kept rd", {27'b0, out_rd_addr}, 32'd12);
    applyStimulus("DIV after flush", F3_DIV, 32'd100, 32'd7, 5'd13, 32'd14, 34);

    // Asynchronous reset in the middle of a multiply.
    start = 1'b1; in_funct3 = F3_MUL; in_rs1_data = 32'd9; in_rs2_data = 32'd9; in_rd_addr = 5'd14;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset done", {31'b0, done}, 32'h0);
    checkOutput("midreset stall_req", {31'b0, stall_req}, 32'h0);
    checkOutput("midreset out_result", out_result, 32'h0);
    checkOutput("midreset out_rd_addr", {27'b0, out_rd_addr}, 32'h0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    applyStimulus("MUL after reset", F3_MUL, 32'd9, 32'd9, 5'd14, 32'd81, 34);

    // Random traffic, including back-to-back accepts and stray flushes.
    for (int i = 0; i < 1500; i++) begin
      start       = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 49) == 0);
      in_funct3   = 3'($urandom_range(0, 7));
      in_rs1_data = pickOperand();
      in_rs2_data = pickOperand();
      in_rd_addr  = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
    end
    start = 1'b0;
    flush = 1'b0;
    repeat (40) begin @(posedge clk); #1; end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the execute stage of the mini CPU. It consumes the decoded operands, funct3/funct7 and rd address held in the ID/EX pipeline register and computes all eight M-extension operations in 34 cycles (1 cycle for divide special cases). While it works it holds the front of the pipeline with a stall request, then returns the result and rd address with a one-cycle `done` strobe for writeback.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk` input 1: pipeline clock.
- `reset` input 1: asynchronous, active-low (asserted at 0); all state returns to IDLE.
- `start` input 1: ID/EX holds an M-op (valid, OP opcode, funct7 = 0000001).
- `flush` input 1: pipeline flush; aborts any operation.
- `in_funct3` input 3: operation select.
- `in_rs1_data`, `in_rs2_data` input 32: operands.
- `in_rd_addr` input 5: destination register.
- `stall_req` output 1: hold IF/ID and ID/EX.
- `done` output 1: one-cycle result strobe.
- `out_result` output 32: result; held until the next `done`.
- `out_rd_addr` output 5: rd of the finishing op; held with the result.

## Operation
- funct3: 000 MUL (low 32 bits), 001 MULH (s×s, high), 010 MULHSU (rs1 signed × rs2 unsigned, high), 011 MULHU (u×u, high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States: IDLE, CALC, FIX, DONE.
- Accept: `start`=1 and `flush`=0 in IDLE or DONE. Operands, funct3 and rd are latched. Signed operands are converted to magnitudes. The result sign is recorded: product sign = sign1 XOR sign2; quotient sign = sign1 XOR sign2; remainder sign = sign1.
- Fast path on accept, going straight to DONE:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC: 32 iterations, driven by a 5-bit counter that wraps 31→0 on exit.
  - Multiply: radix-2 shift-add into a 64-bit product register.
  - Divide: restoring shift-subtract. Quotient and remainder are 32 bits each, with a 33-bit trial subtract.
- FIX: 2's-complement negation where the recorded sign requires it. Negation covers the 64-bit product or the quotient/remainder. The correct half is then selected into `out_result`.
- DONE: `done`=1 for one cycle. Next state is IDLE, or CALC/DONE if a new `start` is accepted in this cycle (back-to-back).
- `start` in CALC/FIX is ignored; the pipeline is stalled, so ID/EX keeps presenting the same op.
- `flush` in any state: IDLE on the next edge, no `done`. `flush` takes priority over `start`. `out_result`/`out_rd_addr` keep their previous values.
- `rd_addr` = 0 is computed normally; writeback discards it.

## Timing
- Reset values: `stall_req`=0 (with `start`=0), `done`=0, `out_result`=0, `out_rd_addr`=0, state IDLE, counter 0.
- Accept at edge E0. CALC runs after E0 through E32 (iterations at E1..E32). FIX follows after E32, then DONE after E33. `done` is high between E33 and E34, i.e. 34-cycle latency.
- Fast path: DONE after E0; `done` is high in the next cycle (1-cycle latency).
- `stall_req` = (`start` AND state∈{IDLE,DONE} AND NOT `flush`) OR state∈{CALC,FIX}. It is combinational from `start`, so ID/EX holds from the accept cycle. It is low in the DONE cycle unless a new op is accepted.
- `out_result`/`out_rd_addr` are registered. They update on the edge entering DONE.
- Reset mid-operation: immediate IDLE; outputs go to 0 asynchronously.

## Structure
- Shared package `mini_cpu_pkg`:
  - `FUNCT7_MULDIV` = 7'b0000001.
  - funct3 constants `F3_MUL` … `F3_REMU`.
  - State enum `muldiv_state_t`.
  - Constant `MULDIV_ITER` = 32.
- Single module, no sub-module. The shared shift/add-subtract datapath, sign handling and FSM fit in one block of roughly 250 lines.

## Test plan
- MUL 7 × 0xFFFFFFFD, rd = 5 → `out_result` 0xFFFFFFEB, `out_rd_addr` 5, `done` exactly 34 cycles after accept, `stall_req` high for the accept cycle through cycle 33.
- High-half products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - All four have `done` one cycle after accept.
- Back-to-back: a second MUL with `start` held in the DONE cycle is accepted. The second `done` comes 34 cycles later with the correct result, and there is no idle gap.
- Flush and reset:
  - `flush` 10 cycles into a DIV → IDLE next edge, no `done`, previous `out_result` retained.
  - A new op is accepted the next cycle.
  - `reset`=0 mid-MUL → all outputs 0 immediately.
